// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter peripheral.
package uart_pkg;

   localparam int UART_DATA_BITS  = 8;
   localparam int UART_FRAME_BITS = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO.
// A push into a full FIFO is still taken when a pop happens in the same cycle.
module uart_tx_fifo
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
)
(
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_data,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_pop;
   logic             w_do_push;

   assign w_do_pop  = i_pop & (r_count != '0);
   assign w_do_push = i_push & ((r_count != FULL_CNT) | w_do_pop);

   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

   // Storage: written only on an accepted push, so later i_data changes never touch queued bytes.
   always_ff @(posedge i_clk) begin
      if (w_do_push)
         r_mem[r_wr_ptr] <= i_data;
   end

   // Pointers (power-of-two depth, so they wrap naturally) and occupancy count.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO, serialising FSM,
// sticky overflow flag and a done interrupt when the queue drains.
module uart_tx_periph
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
)
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_wr_en,
   input  logic [7:0] i_wr_data,
   input  logic       i_irq_en,
   input  logic       i_clr_ovf,
   output logic       o_uart_out,
   output logic       o_tx_busy,
   output logic       o_fifo_full,
   output logic       o_fifo_empty,
   output logic       o_overflow,
   output logic       o_tx_irq
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

   tx_state_t         r_state;
   tx_state_t         w_state_nxt;
   logic [BAUD_W-1:0] r_baud;
   logic [BAUD_W-1:0] w_baud_nxt;
   logic [2:0]        r_bit;
   logic [2:0]        w_bit_nxt;
   logic [7:0]        r_shift;
   logic [7:0]        w_shift_nxt;
   logic              r_ovf;
   logic              r_irq;
   logic              w_irq_nxt;
   logic              w_uart_out;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic              w_has_data;
   logic              w_baud_end;
   logic              w_drop;
   logic [7:0]        w_head;
   logic [CNT_W-1:0]  w_count;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (i_wr_en),
      .i_pop   (w_pop),
      .i_data  (i_wr_data),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign w_has_data = (w_count != '0);
   assign w_baud_end = (r_baud == BAUD_LAST);
   // A write into a full FIFO is lost only if nothing leaves that same cycle.
   assign w_drop     = i_wr_en & w_full & ~w_pop;

   // Next-state, pop request and line level for the frame serialiser.
   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud + 1'b1;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_pop       = 1'b0;
      w_irq_nxt   = 1'b0;
      w_uart_out  = 1'b1;
      case (r_state)
         IDLE: begin
            w_baud_nxt = '0;
            if (w_has_data) begin
               w_pop       = 1'b1;
               w_shift_nxt = w_head;
               w_state_nxt = START;
            end
         end
         START: begin
            w_uart_out = 1'b0;
            if (w_baud_end) begin
               w_baud_nxt  = '0;
               w_bit_nxt   = '0;
               w_state_nxt = DATA;
            end
         end
         DATA: begin
            w_uart_out = r_shift[0];
            if (w_baud_end) begin
               w_baud_nxt  = '0;
               w_shift_nxt = r_shift >> 1;
               if (r_bit == BIT_LAST)
                  w_state_nxt = STOP;
               else
                  w_bit_nxt = r_bit + 3'd1;
            end
         end
         STOP: begin
            w_uart_out = 1'b1;
            if (w_baud_end) begin
               w_baud_nxt = '0;
               // Chain straight into the next frame when more bytes are queued.
               if (w_has_data) begin
                  w_pop       = 1'b1;
                  w_shift_nxt = w_head;
                  w_state_nxt = START;
               end else begin
                  w_irq_nxt   = i_irq_en;
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_baud_nxt  = '0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // FSM, baud counter, bit index and shift register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
      end
   end

   // Sticky overflow (a new drop wins over a clear) and one-cycle done pulse.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ovf <= 1'b0;
         r_irq <= 1'b0;
      end else begin
         if (w_drop)
            r_ovf <= 1'b1;
         else if (i_clr_ovf)
            r_ovf <= 1'b0;
         r_irq <= w_irq_nxt;
      end
   end

   assign o_uart_out   = w_uart_out;
   assign o_tx_busy    = (r_state != IDLE);
   assign o_fifo_full  = w_full;
   assign o_fifo_empty = w_empty;
   assign o_overflow   = r_ovf;
   assign o_tx_irq     = r_irq;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph (CLKS_PER_BIT=16, FIFO_DEPTH=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_periph;

   logic       i_clk;
   logic       i_rst;
   logic       i_wr_en;
   logic [7:0] i_wr_data;
   logic       i_irq_en;
   logic       i_clr_ovf;
   logic       o_uart_out;
   logic       o_tx_busy;
   logic       o_fifo_full;
   logic       o_fifo_empty;
   logic       o_overflow;
   logic       o_tx_irq;

   int n_checks = 0;
   int n_errors = 0;

   uart_tx_periph #(
      .CLKS_PER_BIT (16),
      .FIFO_DEPTH   (4)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_wr_en      (i_wr_en),
      .i_wr_data    (i_wr_data),
      .i_irq_en     (i_irq_en),
      .i_clr_ovf    (i_clr_ovf),
      .o_uart_out   (o_uart_out),
      .o_tx_busy    (o_tx_busy),
      .o_fifo_full  (o_fifo_full),
      .o_fifo_empty (o_fifo_empty),
      .o_overflow   (o_overflow),
      .o_tx_irq     (o_tx_irq)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered on the falling edge of the first start-bit cycle; leaves on the
   // falling edge of the first cycle after the stop bit.
   task automatic frame(input logic [7:0] b, input string tag);
      logic e;
      chk({tag, ":irq_at_start"}, o_tx_irq, 1'b0);
      for (int bi = 0; bi < 10; bi++) begin
         e = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
         for (int c = 0; c < 16; c++) begin
            if (c == 0 || c == 15) begin
               chk($sformatf("%s:bit%0d_c%0d", tag, bi, c), o_uart_out, e);
               chk($sformatf("%s:busy%0d_c%0d", tag, bi, c), o_tx_busy, 1'b1);
            end
            @(negedge i_clk);
            i_wr_en = 1'b0;
         end
      end
   endtask

   // Push one byte from idle; leaves on the first start-bit sample.
   task automatic wr(input logic [7:0] b, input string tag);
      i_wr_en   = 1'b1;
      i_wr_data = b;
      @(negedge i_clk);
      i_wr_en   = 1'b0;
      i_wr_data = ~b;
      chk({tag, ":line_before_start"}, o_uart_out, 1'b1);
      chk({tag, ":not_empty"}, o_fifo_empty, 1'b0);
      @(negedge i_clk);
   endtask

   task automatic done_irq(input string tag, input logic exp_irq);
      chk({tag, ":irq"}, o_tx_irq, exp_irq);
      chk({tag, ":idle_busy"}, o_tx_busy, 1'b0);
      chk({tag, ":idle_line"}, o_uart_out, 1'b1);
      chk({tag, ":idle_empty"}, o_fifo_empty, 1'b1);
      @(negedge i_clk);
      chk({tag, ":irq_gone"}, o_tx_irq, 1'b0);
   endtask

   initial begin
      int n;
      i_rst     = 1'b1;
      i_wr_en   = 1'b0;
      i_wr_data = 8'h00;
      i_irq_en  = 1'b1;
      i_clr_ovf = 1'b0;

      // Reset held 4 cycles
      for (int k = 0; k < 4; k++) begin
         @(negedge i_clk);
         chk("rst:line", o_uart_out, 1'b1);
         chk("rst:empty", o_fifo_empty, 1'b1);
         chk("rst:full", o_fifo_full, 1'b0);
         chk("rst:busy", o_tx_busy, 1'b0);
         chk("rst:irq", o_tx_irq, 1'b0);
         chk("rst:ovf", o_overflow, 1'b0);
      end
      i_rst = 1'b0;
      @(negedge i_clk);

      // Single frame 0xA5
      wr(8'hA5, "a5");
      frame(8'hA5, "a5");
      done_irq("a5", 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(negedge i_clk);
         chk("a5:quiet_irq", o_tx_irq, 1'b0);
         chk("a5:quiet_line", o_uart_out, 1'b1);
      end

      // Back-to-back 0x00, 0xFF, 0x3C
      i_wr_en = 1'b1;
      i_wr_data = 8'h00;
      @(negedge i_clk);
      i_wr_data = 8'hFF;
      chk("b2b:line_before_start", o_uart_out, 1'b1);
      @(negedge i_clk);
      i_wr_data = 8'h3C;
      frame(8'h00, "b2b0");
      frame(8'hFF, "b2b1");
      frame(8'h3C, "b2b2");
      done_irq("b2b", 1'b1);

      // Overflow: six writes while first frame runs; byte 6 is dropped
      @(negedge i_clk);
      n = 0;
      i_wr_en = 1'b1;
      i_wr_data = 8'h11;
      @(negedge i_clk); n++;
      i_wr_data = 8'h22;
      @(negedge i_clk); n++;
      chk("ovf:frame1_start", o_uart_out, 1'b0);
      i_wr_data = 8'h33;
      @(negedge i_clk); n++;
      i_wr_data = 8'h44;
      @(negedge i_clk); n++;
      i_wr_data = 8'h55;
      @(negedge i_clk); n++;
      chk("ovf:full_after4", o_fifo_full, 1'b1);
      chk("ovf:no_ovf_yet", o_overflow, 1'b0);
      i_wr_data = 8'h66;
      @(negedge i_clk); n++;
      chk("ovf:set", o_overflow, 1'b1);
      chk("ovf:still_full", o_fifo_full, 1'b1);
      i_wr_en = 1'b0;
      i_clr_ovf = 1'b1;
      @(negedge i_clk); n++;
      chk("ovf:cleared", o_overflow, 1'b0);
      i_wr_en = 1'b1;
      i_wr_data = 8'h77;
      @(negedge i_clk); n++;
      chk("ovf:drop_beats_clear", o_overflow, 1'b1);
      i_wr_en = 1'b0;
      i_clr_ovf = 1'b0;
      @(negedge i_clk); n++;
      chk("ovf:sticky", o_overflow, 1'b1);
      i_clr_ovf = 1'b1;
      @(negedge i_clk); n++;
      chk("ovf:cleared2", o_overflow, 1'b0);
      i_clr_ovf = 1'b0;
      while (n < 161) begin
         @(negedge i_clk); n++;
      end
      chk("ovf:full_before_pop", o_fifo_full, 1'b1);
      @(negedge i_clk); n++;
      frame(8'h22, "ovf2");
      frame(8'h33, "ovf3");
      frame(8'h44, "ovf4");
      frame(8'h55, "ovf5");
      done_irq("ovf", 1'b1);

      // Reset in the middle of 0x55 with another byte queued
      @(negedge i_clk);
      wr(8'h55, "rmid");
      i_wr_en = 1'b1;
      i_wr_data = 8'h12;
      for (int k = 0; k < 40; k++) begin
         @(negedge i_clk);
         i_wr_en = 1'b0;
      end
      chk("rmid:line_pre", o_uart_out, 1'b0);
      chk("rmid:queued", o_fifo_empty, 1'b0);
      i_rst = 1'b1;
      #1;
      chk("rmid:line_now", o_uart_out, 1'b1);
      chk("rmid:busy", o_tx_busy, 1'b0);
      chk("rmid:empty", o_fifo_empty, 1'b1);
      chk("rmid:irq", o_tx_irq, 1'b0);
      @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
      chk("rmid:idle_line", o_uart_out, 1'b1);
      chk("rmid:idle_busy", o_tx_busy, 1'b0);
      wr(8'hC3, "rnew");
      frame(8'hC3, "rnew");
      done_irq("rnew", 1'b1);

      // Interrupt masked for 0x81, enabled for 0x7E
      i_irq_en = 1'b0;
      @(negedge i_clk);
      wr(8'h81, "mask");
      frame(8'h81, "mask");
      done_irq("mask", 1'b0);
      i_irq_en = 1'b1;
      @(negedge i_clk);
      chk("mask:late_enable", o_tx_irq, 1'b0);
      wr(8'h7E, "unmask");
      frame(8'h7E, "unmask");
      done_irq("unmask", 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
